// File: rtl/keccak_pad_ctrl.sv
// keccak_pad_ctrl: collects 32-bit message words into a 544-bit rate block
// (17 words) and applies Keccak multi-rate padding on the final word.
// Optional feature macro: KECCAK_PAD_FINAL_BIT_EN -- when defined, the
// closing pad bit (blk_data[7]) is forced to 1 on blocks that carry padding.
//
// state | meaning
// FILL  | accepting message words into slot wcnt
// PAD   | writing zero words into the remaining slots after a last word
// FULL  | block presented, held stable until blk_ack

module keccak_pad_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         in_ready,
    output logic [543:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ack
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_wcnt;
    logic [31:0] r_buf [17];
    logic        r_in_ready;
    logic        r_blk_valid;
    logic        r_blk_last;

    logic [31:0]  w_last_word;
    logic [543:0] w_flat;

    // Keep the first in_bytes bytes of the final word and append the 0x01 pad byte.
    always_comb begin
        w_last_word = 32'h0100_0000;
        case (in_bytes)
            2'd0: w_last_word = 32'h0100_0000;
            2'd1: w_last_word = {in_data[31:24], 24'h01_0000};
            2'd2: w_last_word = {in_data[31:16], 16'h0100};
            2'd3: w_last_word = {in_data[31:8], 8'h01};
            default: w_last_word = 32'h0100_0000;
        endcase
    end

    // Word 0 occupies the most significant 32 bits of the block.
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < 17; i++) begin
            w_flat[543 - 32*i -: 32] = r_buf[i];
        end
    end

    // Control FSM: fill, pad, present; all outputs are registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_wcnt      <= 5'd0;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            for (int i = 0; i < 17; i++) begin
                r_buf[i] <= 32'h0;
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        r_buf[r_wcnt] <= in_last ? w_last_word : in_data;
                        if (r_wcnt == 5'd16) begin
                            // Slot 16 completes the block whether or not it is last.
                            r_state     <= FULL;
                            r_in_ready  <= 1'b0;
                            r_blk_valid <= 1'b1;
                            r_blk_last  <= in_last;
                        end else begin
                            r_wcnt <= r_wcnt + 5'd1;
                            if (in_last) begin
                                r_state    <= PAD;
                                r_in_ready <= 1'b0;
                                r_blk_last <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    r_buf[r_wcnt] <= 32'h0;
                    if (r_wcnt == 5'd16) begin
                        r_state     <= FULL;
                        r_blk_valid <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 5'd1;
                    end
                end
                FULL: begin
                    if (blk_ack) begin
                        r_state     <= FILL;
                        r_wcnt      <= 5'd0;
                        r_in_ready  <= 1'b1;
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        for (int i = 0; i < 17; i++) begin
                            r_buf[i] <= 32'h0;
                        end
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_wcnt     <= 5'd0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign blk_valid = r_blk_valid;
    assign blk_last  = r_blk_last;

`ifdef KECCAK_PAD_FINAL_BIT_EN
    // The closing pad10*1 bit lands in bit 7 and merges with any 0x01 already there.
    assign blk_data = w_flat | {536'd0, r_blk_last, 7'd0};
`else
    assign blk_data = w_flat;
`endif

endmodule

// File: tb/tb_keccak_pad_ctrl.sv
// Testbench for keccak_pad_ctrl: transaction-level model of the rate block
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_keccak_pad_ctrl;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         in_ready;
    logic [543:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ack;

    keccak_pad_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_bytes (in_bytes),
        .in_ready (in_ready),
        .blk_data (blk_data),
        .blk_valid(blk_valid),
        .blk_last (blk_last),
        .blk_ack  (blk_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

`ifdef KECCAK_PAD_FINAL_BIT_EN
    localparam bit FINAL_BIT = 1'b1;
`else
    localparam bit FINAL_BIT = 1'b0;
`endif

    // Model: message words per slot, block status, expected arrival cycle.
    logic [31:0] m_slots [17];
    int          m_j = 0;
    bit          m_last = 1'b0;
    bit          m_pending = 1'b0;
    int          m_due = 0;
    int          m_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [543:0] got, input logic [543:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pad_word(input logic [31:0] d, input int k);
        logic [31:0] keep;
        keep = ~(32'hFFFF_FFFF >> (8 * k));
        if (k == 0) keep = 32'h0;
        return (d & keep) | (32'h01 << (8 * (3 - k)));
    endfunction

    function automatic logic [543:0] model_block();
        logic [543:0] b;
        b = '0;
        for (int i = 0; i < 17; i++) b[543 - 32*i -: 32] = m_slots[i];
        if (FINAL_BIT && m_last) b[7] = 1'b1;
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 17; i++) m_slots[i] = 32'h0;
        m_j = 0;
        m_last = 1'b0;
        m_pending = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic last, input int k);
        int slot;
        slot = m_j;
        m_slots[slot] = last ? pad_word(d, k) : d;
        m_j++;
        if (last) begin
            m_last = 1'b1;
            m_pending = 1'b1;
            m_due = cyc + (16 - slot) + 1;
            m_acc_cyc = cyc;
        end else if (slot == 16) begin
            m_pending = 1'b1;
            m_due = cyc + 1;
            m_acc_cyc = cyc;
        end
    endtask

    // Per-cycle comparison of DUT outputs with the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_v;
            exp_v = m_pending && (cyc >= m_due);
            chk("blk_valid", {31'd0, blk_valid}, {31'd0, exp_v});
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
            if (exp_v && blk_valid) begin
                chk_wide("blk_data", blk_data, model_block());
                chk("blk_last", {31'd0, blk_last}, {31'd0, m_last});
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input int k);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        while (!in_ready && guard < 50) begin
            in_valid = 1'b0;
            guard++;
            @(negedge clk); #1;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word: in_ready stuck low, got 0 expected 1");
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = k[1:0];
        model_accept(d, last, k);
    endtask

    task automatic wait_valid(output int vc);
        int n;
        n = 0;
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!blk_valid && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (!blk_valid) begin
            errors++;
            $display("FAIL wait_valid: blk_valid got 0 expected 1 within 40 cycles");
        end
        vc = cyc;
    endtask

    task automatic ack();
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        blk_ack  = 1'b1;
        model_clear();
        @(negedge clk); #1;
        blk_ack = 1'b0;
        chk("in_ready_after_ack", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        logic [543:0] exp_b;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_bytes = '0; blk_ack = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_blk_valid", {31'd0, blk_valid}, 32'd0);
        chk("rst_blk_last", {31'd0, blk_last}, 32'd0);
        chk_wide("rst_blk_data", blk_data, 544'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Single last word, k=0, into slot 0: 16 PAD cycles.
        send_word(32'hAABB_CCDD, 1'b1, 0);
        wait_valid(vc);
        chk("lat_slot0", vc - m_acc_cyc, 32'd17);
        exp_b = {32'h0100_0000, 512'd0};
        if (FINAL_BIT) exp_b[7] = 1'b1;
        chk_wide("k0_block", blk_data, exp_b);
        chk("k0_last", {31'd0, blk_last}, 32'd1);
        ack();

        // 17 plain words, slot n holds n.
        for (int n = 0; n < 17; n++) send_word(n, 1'b0, 0);
        wait_valid(vc);
        chk("lat_full17", vc - m_acc_cyc, 32'd1);
        chk("w17_word0", blk_data[543:512], 32'd0);
        chk("w17_word15", blk_data[63:32], 32'd15);
        chk("w17_word16", blk_data[31:0], 32'd16);
        chk("w17_last", {31'd0, blk_last}, 32'd0);
        ack();

        // 16 words then last word k=3 into slot 16: pad byte merges with final bit.
        for (int n = 0; n < 16; n++) send_word(32'hA000_0000 + n, 1'b0, 0);
        send_word(32'h1122_3344, 1'b1, 3);
        wait_valid(vc);
        chk("lat_slot16", vc - m_acc_cyc, 32'd1);
        chk("k3_slot16", blk_data[31:0], FINAL_BIT ? 32'h1122_3381 : 32'h1122_3301);
        chk("k3_last", {31'd0, blk_last}, 32'd1);
        ack();

        // Stray ack during FILL, then last word k=1 into slot 5.
        blk_ack = 1'b1;
        for (int n = 0; n < 5; n++) send_word(32'h5000_0000 + n, 1'b0, 0);
        blk_ack = 1'b0;
        send_word(32'hCAFE_BABE, 1'b1, 1);
        wait_valid(vc);
        chk("lat_slot5", vc - m_acc_cyc, 32'd12);
        chk("k1_slot5", blk_data[543 - 160 -: 32], 32'hCA01_0000);
        chk("k1_slot0", blk_data[543:512], 32'h5000_0000);
        ack();

        // Last word k=2 into slot 10.
        for (int n = 0; n < 10; n++) send_word(32'h7700_0000 + n, 1'b0, 0);
        send_word(32'h1234_5678, 1'b1, 2);
        wait_valid(vc);
        chk("lat_slot10", vc - m_acc_cyc, 32'd7);
        chk("k2_slot10", blk_data[543 - 320 -: 32], 32'h1234_0100);
        ack();

        // Hold a full block for 5 cycles while in_valid stays high.
        for (int n = 0; n < 17; n++) send_word(32'h3300_0000 + n, 1'b0, 0);
        wait_valid(vc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            @(negedge clk); #1;
        end
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold_word16", blk_data[31:0], 32'h3300_0010);
        ack();

        // Reset pulse during PAD after a last word into slot 3.
        for (int n = 0; n < 3; n++) send_word(32'h4400_0000 + n, 1'b0, 0);
        send_word(32'h5566_7788, 1'b1, 2);
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rstpad_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstpad_blk_valid", {31'd0, blk_valid}, 32'd0);
        chk("rstpad_blk_last", {31'd0, blk_last}, 32'd0);
        chk_wide("rstpad_blk_data", blk_data, 544'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 17; n++) send_word(32'h100 + n, 1'b0, 0);
        wait_valid(vc);
        chk("post_rst_last", {31'd0, blk_last}, 32'd0);
        chk("post_rst_word0", blk_data[543:512], 32'h0000_0100);
        chk("post_rst_word3", blk_data[543 - 96 -: 32], 32'h0000_0103);
        ack();

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_pad_ctrl.md
KECCAK_PAD_CTRL -- requirements
Module: keccak_pad_ctrl

Interface
REQ-001 Ports SHALL be, one per line (name  direction  width  meaning):
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_data  in  32  message word; in_data[31:24] is the first byte.
REQ-005 in_valid  in  1  in_data holds a word.
REQ-006 in_last  in  1  qualifies in_data as the final message word.
REQ-007 in_bytes  in  2  count of valid bytes (0-3) in a last word; ignored when in_last=0.
REQ-008 in_ready  out  1  block accepts a word this cycle.
REQ-009 blk_data  out  544  rate block; word 0 maps to [543:512], word 16 to [31:0].
REQ-010 blk_valid  out  1  blk_data is complete and stable.
REQ-011 blk_last  out  1  the presented block carries the message padding.
REQ-012 blk_ack  in  1  consumer takes the block; sampled only while blk_valid=1.

Function
REQ-013 A word transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; a non-last word SHALL carry 4 message bytes.
REQ-014 The FSM SHALL have three states: FILL, PAD and FULL.
REQ-015 FILL: in_ready=1; each accepted word SHALL be stored at slot wcnt, and wcnt SHALL increment (5-bit, range 0-16).
REQ-016 FILL, non-last word into slot 16: next state SHALL be FULL with blk_last=0.
REQ-017 FILL, last word with k=in_bytes: the stored word SHALL be the first k bytes of in_data, then 0x01, then zero bytes; k=0 stores 0x01000000.
REQ-018 A last word into slot 16 SHALL go to FULL; a last word into any slot below 16 SHALL go to PAD; both SHALL set blk_last=1.
REQ-019 PAD: in_ready=0; one zero word per cycle SHALL be written into the remaining slots; after slot 16 is written the FSM SHALL go to FULL.
REQ-020 FULL: in_ready=0 and blk_valid=1; blk_data and blk_last SHALL stay stable until blk_ack.
REQ-021 The blk_ack cycle in FULL SHALL clear the buffer, wcnt and blk_last and return to FILL; blk_valid=0 and in_ready=1 on the next cycle.
REQ-022 A padding byte falling in byte 67 (last word into slot 16 with k=3) SHALL merge with the final-bit rule of REQ-027 and SHALL never cause an extra block.
REQ-023 blk_ack outside FULL SHALL be ignored; in_valid while in_ready=0 SHALL NOT be consumed.
REQ-024 Latency: the last word accepted into slot j SHALL give blk_valid=1 (16-j)+1 cycles later.

Reset
REQ-025 While rst_n=0, asynchronously: state=FILL, wcnt=0, buffer=0, in_ready=1, blk_valid=0, blk_last=0, blk_data=0.
REQ-026 Reset asserted mid-block or during PAD/FULL SHALL discard all buffered data without producing a block.

Configuration
REQ-027 Macro KECCAK_PAD_FINAL_BIT_EN defined: when blk_last=1, blk_data[7] SHALL be ORed to 1 (pad10*1 closing bit).
REQ-028 Macro KECCAK_PAD_FINAL_BIT_EN undefined: the padding SHALL be the 0x01 byte only, and blk_data[7] SHALL be unmodified.

Verification
REQ-029 Reset, then a single last word 0xAABBCCDD with k=0 -> PAD 16 cycles; blk_data[543:512]=0x01000000, all other bits 0 except bit 7 (with macro); blk_last=1.
REQ-030 Words 0x00000000..0x00000010 (17 words, none last) -> blk_valid 1 cycle after word 17; blk_last=0; slot n=n; no padding bytes.
REQ-031 16 words, then a last word 0x11223344 with k=3 -> no PAD cycles; blk_data[31:0]=0x11223381 with macro, 0x11223301 without.
REQ-032 Block held 5 cycles with blk_ack=0 while in_valid=1 -> blk_data stable, in_ready=0, no words consumed; ack -> in_ready=1 next cycle.
REQ-033 rst_n pulsed low during PAD after a last word into slot 3 -> outputs reach reset values immediately; next 17 words produce a clean block with blk_last=0.
